// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed FIR sequencer: one MAC steps over TAPS coefficients per sample.
// Ports: in_* / out_* valid-ready streams, coef_* config write port, busy status.
module fir_serial_ctrl #(
  parameter int WIDTH       = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 25,
  parameter int ACC_WIDTH   = WIDTH + COEFF_WIDTH + $clog2(TAPS),
  localparam int AW         = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        coef_we,
  input  logic [AW-1:0]               coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  output logic                        busy
);

  localparam int PW = WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [WIDTH-1:0]       dline [TAPS];
  logic signed [COEFF_WIDTH-1:0] coef  [TAPS];
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 k;
  logic signed [ACC_WIDTH-1:0]   acc;

  logic [AW-1:0]                 rd;
  logic signed [PW-1:0]          prod;
  logic [ACC_WIDTH-1:0]          prod_x;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic                          last;
  logic                          addr_ok;

  // x[n-k] lives at (wr_ptr - k) mod TAPS
  always_comb begin
    if (k > wr_ptr)
      rd = AW'({1'b0, wr_ptr} + (AW+1)'(TAPS) - {1'b0, k});
    else
      rd = wr_ptr - k;
  end

  assign prod    = coef[k] * dline[rd];
  assign prod_x  = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign sum     = acc + prod_x;
  assign last    = (k == AW'(TAPS-1));
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (in_valid)  state_d = MAC;
      state_q == MAC:  if (last)      state_d = DONE;
      state_q == DONE: if (out_ready) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          // write lands before the MAC reads it, so a same-cycle
          // sample already sees the new coefficient
          if (coef_we && addr_ok) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            dline[wr_ptr] <= in_data;
            acc           <= '0;
            k             <= '0;
          end
        end
        state_q == MAC: begin
          acc <= sum;
          k   <= k + 1'b1;
          if (last) out_data <= sum;
        end
        state_q == DONE: begin
          if (out_ready) begin
            if (wr_ptr == AW'(TAPS-1)) wr_ptr <= '0;
            else                       wr_ptr <= wr_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Randomized bench for fir_serial_ctrl against a direct-form FIR sum model.
// Covers impulse, worst-case magnitude, backpressure, busy writes, wrap, reset.
module tb_fir_serial_ctrl;

  localparam int TAPS = 25;
  localparam int AW   = 5;

  logic               clk = 0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [36:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [15:0] coef_data;
  logic               busy;

  int nvec = 0;
  int nbad = 0;

  longint mc [TAPS];
  longint hist [$];
  longint last_y;

  fir_serial_ctrl dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y[n] = sum_k c[k] * x[n-k], with x before the first sample = 0
  function automatic longint model();
    longint s = 0;
    for (int j = 0; j < TAPS; j++) begin
      int i = hist.size() - 1 - j;
      if (i >= 0) s += mc[j] * hist[i];
    end
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int j = 0; j < TAPS; j++) mc[j] = 0;
  endtask

  task automatic wr_coef(input logic [AW-1:0] a, input logic signed [15:0] d);
    @(negedge clk);
    coef_we = 1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 0;
    if (a < TAPS) mc[a] = d;
  endtask

  task automatic send(input logic signed [15:0] x, input int hold,
                      input bit we, input logic [AW-1:0] wa,
                      input logic signed [15:0] wd, input bit mac_we);
    int n;
    longint y;
    longint held;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_data = x; in_valid = 1;
    coef_we = we; coef_addr = wa; coef_data = wd;
    if (we && wa < TAPS) mc[wa] = wd;
    hist.push_back(x);
    y = model();
    @(negedge clk);
    in_valid = 0; coef_we = 0;
    n = 1;
    // n counts cycles from the one presenting in_valid
    while (!out_valid && n < 100) begin
      if (mac_we && n == 3) begin
        coef_we = 1; coef_addr = 0; coef_data = 100;
      end else coef_we = 0;
      @(negedge clk);
      n++;
    end
    coef_we = 0;
    chk("latency", n, TAPS + 1);
    chk("out_data", out_data, y);
    last_y = out_data;
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1;
      in_data = 16'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_data", out_data, held);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("to_idle", busy, 0);
  endtask

  task automatic s(input logic signed [15:0] x);
    send(x, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic impulse();
    for (int j = 0; j < TAPS; j++) wr_coef(AW'(j), 16'(j + 1));
    for (int j = 0; j < TAPS + 2; j++) begin
      s(j == 0 ? 16'sd1 : 16'sd0);
      chk("impulse", last_y, j < TAPS ? j + 1 : 0);
    end
  endtask

  initial begin
    rst = 0; in_data = 0; in_valid = 0; out_ready = 0;
    coef_we = 0; coef_addr = 0; coef_data = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    rst = 1;

    impulse();

    do_reset();
    for (int j = 0; j < TAPS; j++) wr_coef(AW'(j), -16'sd32768);
    for (int j = 0; j < TAPS; j++) s(-16'sd32768);
    chk("worst_pos", last_y, 64'sd26843545600);
    for (int j = 0; j < TAPS; j++) wr_coef(AW'(j), 16'sd32767);
    s(-16'sd32768);
    chk("worst_neg", last_y, -64'sd25 * 64'sd32767 * 64'sd32768);

    send(16'sd1234, 10, 0, '0, '0, 0);

    send(16'sd77, 0, 0, '0, '0, 1);
    s(16'sd3);
    wr_coef('0, 16'sd100);
    s(16'sd5);
    chk("coef0_new", mc[0], 100);

    do_reset();
    for (int j = 0; j < TAPS; j++) wr_coef(AW'(j), 16'sd1);
    for (int j = 0; j < 60; j++) begin
      s(16'(j));
      if (j >= 24) chk("wrap_sum", last_y, 25 * j - 300);
    end

    @(negedge clk);
    in_data = 16'sd5; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    chk("mid_mac_busy", busy, 1);
    do_reset();
    impulse();

    for (int j = 0; j < 40; j++) begin
      bit we;
      we = ($urandom_range(0, 2) == 0);
      send(16'($urandom), $urandom_range(0, 2), we,
           AW'($urandom_range(0, 31)), 16'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
